// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W payload bits LSB first, optional even parity, stop bit.
// Define RX_PARITY_EN to add the parity bit (state PAR) after the payload.
module serial_frame_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clkAB,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              din,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
`ifdef RX_PARITY_EN
        PAR   = 3'd2,
`endif
        STOP  = 3'd3,
        WAIT1 = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               din_q;
    logic               par_err;

`ifdef RX_PARITY_EN
    logic par_q, par_d;
    // Even parity: payload plus parity bit must hold an even number of ones.
    assign par_err = ^{shift_q, par_q};
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clkAB) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            din_q       <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`ifdef RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            din_q       <= din;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`ifdef RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
`ifdef RX_PARITY_EN
        par_d       = par_q;
`endif
        if (!rx_en) begin
            // Disabling drops any partial frame silently.
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!din_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = din_q;
                    if (idx_q == LAST_IDX) begin
`ifdef RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PAR: begin
                    par_d   = din_q;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (din_q && !par_err) begin
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        state_d = WAIT1;
                    end
                end
                // A broken frame may leave the line low; wait for idle before hunting a start bit.
                WAIT1: begin
                    if (din_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx; a second instance with CNT_W=2 exercises counter wrap/saturation.
module tb_serial_frame_rx;

`ifdef RX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic       clkAB = 1'b0;
    logic       rst   = 1'b0;
    logic       rx_en = 1'b0;
    logic       din   = 1'b1;
    logic [7:0] rx_data, rx_data2;
    logic       rx_valid, rx_valid2;
    logic       frame_err, frame_err2;
    logic [7:0] frame_cnt, err_cnt;
    logic [1:0] frame_cnt2, err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vcount   = 0;
    int ecount   = 0;
    int both_cnt = 0;
    int last_v   = 0;
    int prev_v   = 0;

    serial_frame_rx #(.DATA_W(8), .CNT_W(8)) dut (
        .clkAB(clkAB), .rst(rst), .rx_en(rx_en), .din(din),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    serial_frame_rx #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clkAB(clkAB), .rst(rst), .rx_en(rx_en), .din(din),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2),
        .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
    );

    always #5 clkAB = ~clkAB;

    always @(posedge clkAB) cyc++;

    // Pulse monitor sampled mid-cycle.
    always @(negedge clkAB) begin
        if (rx_valid === 1'b1) begin
            vcount++;
            prev_v = last_v;
            last_v = cyc;
        end
        if (frame_err === 1'b1) ecount++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic tick();
        @(posedge clkAB);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`else
        if (par_flip) din = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b1;
        rx_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_en = 1'b1; din = 1'b0;
        tick();
        tick();
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        rst = 1'b0; din = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        int v0;
        do_reset();
        v0 = vcount;
        send_frame(8'hA5, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid_latency: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h expected a5", rx_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL good_no_err: got %b expected 0", frame_err); end
        tick();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width: got %b expected 0", rx_valid); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL good_frame_cnt: got %0d expected 1", frame_cnt); end
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL good_pulse_count: got %0d expected 1", vcount - v0); end
    endtask

    task automatic test_stop_error();
        int v0, e0;
        v0 = vcount; e0 = ecount;
        send_frame(8'hA5, 1'b0, 1'b0);
        din = 1'b0;
        tick();
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL stop_err_pulse: got %b expected 1", frame_err); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL stop_err_cnt: got %0d expected 1", err_cnt); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL stop_err_data_kept: got %h expected a5", rx_data); end
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h96, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        tick();
        n_checks++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL wait1_resync_data: got %h expected 96", rx_data); end
        n_checks++; if (ecount - e0 !== 1) begin n_fail++; $display("FAIL wait1_err_pulses: got %0d expected 1", ecount - e0); end
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL wait1_valid_pulses: got %0d expected 1", vcount - v0); end
        n_checks++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL wait1_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int v0;
        do_reset();
        v0 = vcount;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        tick();
        n_checks++; if (vcount - v0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", vcount - v0); end
        n_checks++; if (last_v - prev_v !== FRAME_LEN) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", last_v - prev_v, FRAME_LEN); end
        n_checks++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected 2", frame_cnt); end
        n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_data: got %h expected c3", rx_data); end
    endtask

    task automatic test_rx_en_abort();
        int v0, e0;
        do_reset();
        v0 = vcount; e0 = ecount;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rx_en = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        n_checks++; if (vcount - v0 !== 0 || ecount - e0 !== 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d/%0d pulses expected 0/0", vcount - v0, ecount - e0); end
        rx_en = 1'b1;
        send_bit(1'b1);
        send_frame(8'h11, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        tick();
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL abort_data: got %h expected 11", rx_data); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d expected 1", frame_cnt); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL abort_err_cnt: got %0d expected 0", err_cnt); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        int v0, e0;
        do_reset();
        v0 = vcount; e0 = ecount;
        send_frame(8'hA5, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL parity_ok_valid: got %b expected 1", rx_valid); end
        send_frame(8'hA5, 1'b1, 1'b1);
        din = 1'b1;
        tick();
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_err: got %b expected 1", frame_err); end
        tick();
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL parity_err_cnt: got %0d expected 1", err_cnt); end
        n_checks++; if (vcount - v0 !== 1 || ecount - e0 !== 1) begin n_fail++; $display("FAIL parity_pulses: got %0d/%0d expected 1/1", vcount - v0, ecount - e0); end
    endtask
`endif

    task automatic test_counters();
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'h5A, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        tick();
        n_checks++; if (frame_cnt2 !== 2'd3) begin n_fail++; $display("FAIL cnt2_all_ones: got %0d expected 3", frame_cnt2); end
        send_frame(8'h5A, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        tick();
        n_checks++; if (frame_cnt2 !== 2'd0) begin n_fail++; $display("FAIL cnt2_wrap: got %0d expected 0", frame_cnt2); end
        n_checks++; if (frame_cnt !== 8'd4) begin n_fail++; $display("FAIL cnt8_four: got %0d expected 4", frame_cnt); end
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h0F, 1'b0, 1'b0);
            send_bit(1'b1);
        end
        tick();
        n_checks++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL err2_saturate: got %0d expected 3", err_cnt2); end
        n_checks++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL err8_five: got %0d expected 5", err_cnt); end
        n_checks++; if (frame_cnt2 !== 2'd0) begin n_fail++; $display("FAIL cnt2_after_err: got %0d expected 0", frame_cnt2); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        v0 = vcount; e0 = ecount;
        rst = 1'b1; din = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if ({rx_data, rx_valid, frame_err, frame_cnt, err_cnt} !== 26'd0) begin n_fail++; $display("FAIL midrst_outputs: got %h/%b/%b/%0d/%0d expected all 0", rx_data, rx_valid, frame_err, frame_cnt, err_cnt); end
        n_checks++; if ({rx_data2, rx_valid2, frame_err2, frame_cnt2, err_cnt2} !== 14'd0) begin n_fail++; $display("FAIL midrst_outputs2: got %h/%b/%b/%0d/%0d expected all 0", rx_data2, rx_valid2, frame_err2, frame_cnt2, err_cnt2); end
        send_frame(8'h81, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin n_fail++; $display("FAIL first_start_after_rst: got valid=%b data=%h expected 1/81", rx_valid, rx_data); end
        tick();
        n_checks++; if (vcount - v0 !== 1 || ecount - e0 !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d/%0d expected 1/0", vcount - v0, ecount - e0); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        tick();
        test_reset();
        test_good_frame();
        test_stop_error();
        test_back_to_back();
        test_rx_en_abort();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_counters();
        test_reset_mid_frame();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
